// File: rtl/multi_countdown_timer_pkg.sv
// Shared constants and channel state encoding for the multi-channel countdown timer.
package multi_countdown_timer_pkg;

  localparam int MAX_WIDTH    = 8;
  localparam int COUNTER_1SEC = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/multi_countdown_timer_channel.sv
// One seconds-resolution countdown channel with its own prescaler, pause,
// synchronous clear and optional auto-reload.
module multi_countdown_timer_channel
  import multi_countdown_timer_pkg::*;
#(
  parameter int WIDTH       = MAX_WIDTH,
  parameter int TICK_CYCLES = COUNTER_1SEC
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             clear,
  input  logic             pause,
  input  logic             reload_en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             done_pulse
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic             pulse_q, pulse_d;
  logic             start_prev_q, clear_prev_q;
  logic             start_e, clear_e;

  assign start_e = start & ~start_prev_q;
  assign clear_e = clear & ~clear_prev_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    presc_d   = presc_q;
    done_d    = done_q;
    running_d = running_q;
    pulse_d   = 1'b0;
    if (clear_e) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      presc_d   = '0;
      done_d    = 1'b1;
      running_d = 1'b0;
    end else if (start_e) begin
      if (load_value == '0) begin
        state_d   = ST_IDLE;
        count_d   = '0;
        presc_d   = '0;
        done_d    = 1'b1;
        running_d = 1'b0;
        pulse_d   = 1'b1;
      end else begin
        // The load cycle counts as the first prescaler cycle, so expiry
        // lands exactly load_value*TICK_CYCLES cycles after the start edge.
        state_d   = pause ? ST_PAUSE : ST_RUN;
        count_d   = load_value;
        presc_d   = PW'(1);
        done_d    = 1'b0;
        running_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_RUN, ST_PAUSE: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (count_q == '0) begin
            state_d   = ST_IDLE;
            presc_d   = '0;
            done_d    = 1'b1;
            running_d = 1'b0;
          end else begin
            state_d = ST_RUN;
            if (presc_q == PRE_LAST) begin
              presc_d = '0;
              if (count_q == WIDTH'(1)) begin
                pulse_d = 1'b1;
                if (reload_en && (load_value != '0)) begin
                  count_d = load_value;
                end else begin
                  state_d   = ST_IDLE;
                  count_d   = '0;
                  done_d    = 1'b1;
                  running_d = 1'b0;
                end
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          presc_d   = '0;
          done_d    = 1'b1;
          running_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      presc_q      <= '0;
      done_q       <= 1'b1;
      running_q    <= 1'b0;
      pulse_q      <= 1'b0;
      start_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      presc_q      <= presc_d;
      done_q       <= done_d;
      running_q    <= running_d;
      pulse_q      <= pulse_d;
      start_prev_q <= start;
      clear_prev_q <= clear;
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign done       = done_q;
  assign done_pulse = pulse_q;

endmodule

// File: rtl/multi_countdown_timer.sv
// N independent countdown channels plus a registered OR of their expiry pulses.
module multi_countdown_timer
  import multi_countdown_timer_pkg::*;
#(
  parameter int N_CH        = 2,
  parameter int WIDTH       = MAX_WIDTH,
  parameter int TICK_CYCLES = COUNTER_1SEC
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       clear,
  input  logic [N_CH-1:0]       pause,
  input  logic [N_CH-1:0]       reload_en,
  input  logic [N_CH*WIDTH-1:0] load_value,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       running,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       done_pulse,
  output logic                  any_pulse
);

  logic any_pulse_q, any_pulse_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    multi_countdown_timer_channel #(
      .WIDTH      (WIDTH),
      .TICK_CYCLES(TICK_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start[i]),
      .clear     (clear[i]),
      .pause     (pause[i]),
      .reload_en (reload_en[i]),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .count     (count[i*WIDTH +: WIDTH]),
      .running   (running[i]),
      .done      (done[i]),
      .done_pulse(done_pulse[i])
    );
  end

  always_comb any_pulse_d = |done_pulse;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) any_pulse_q <= 1'b0;
    else       any_pulse_q <= any_pulse_d;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed bench for multi_countdown_timer with TICK_CYCLES=4, WIDTH=8, N_CH=2.
module tb_multi_countdown_timer;

  localparam int N_CH = 2;
  localparam int WIDTH = 8;
  localparam int TICK = 4;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [N_CH-1:0]       start = '0;
  logic [N_CH-1:0]       clear = '0;
  logic [N_CH-1:0]       pause = '0;
  logic [N_CH-1:0]       reload_en = '0;
  logic [N_CH*WIDTH-1:0] load_value = '0;
  logic [N_CH*WIDTH-1:0] count;
  logic [N_CH-1:0]       running;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       done_pulse;
  logic                  any_pulse;

  int total_cnt = 0;
  int pass_cnt  = 0;

  multi_countdown_timer #(
    .N_CH(N_CH), .WIDTH(WIDTH), .TICK_CYCLES(TICK)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .clear(clear), .pause(pause),
    .reload_en(reload_en), .load_value(load_value), .count(count),
    .running(running), .done(done), .done_pulse(done_pulse), .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; cycle numbers in the tests
  // refer to the values visible at this point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    total_cnt++; if (count !== 16'h0000) $display("FAIL reset_count got %h want 0000", count); else pass_cnt++;
    total_cnt++; if (done !== 2'b11) $display("FAIL reset_done got %b want 11", done); else pass_cnt++;
    total_cnt++; if (running !== 2'b00) $display("FAIL reset_running got %b want 00", running); else pass_cnt++;
    total_cnt++; if (done_pulse !== 2'b00) $display("FAIL reset_done_pulse got %b want 00", done_pulse); else pass_cnt++;
    total_cnt++; if (any_pulse !== 1'b0) $display("FAIL reset_any_pulse got %b want 0", any_pulse); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  // ch0 L=3: count 3,2,1,0 from cycles 1,4,8,12; pulse at 12, any_pulse at 13.
  task automatic test_single_shot();
    logic [7:0] exp_c;
    load_value[7:0] = 8'd3;
    start[0] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      exp_c = (c < 4) ? 8'd3 : (c < 8) ? 8'd2 : (c < 12) ? 8'd1 : 8'd0;
      total_cnt++; if (count[7:0] !== exp_c) $display("FAIL single_count c=%0d got %0d want %0d", c, count[7:0], exp_c); else pass_cnt++;
      total_cnt++; if (done[0] !== (c >= 12)) $display("FAIL single_done c=%0d got %b want %b", c, done[0], (c >= 12)); else pass_cnt++;
      total_cnt++; if (done_pulse[0] !== (c == 12)) $display("FAIL single_pulse c=%0d got %b want %b", c, done_pulse[0], (c == 12)); else pass_cnt++;
      total_cnt++; if (running[0] !== (c < 12)) $display("FAIL single_running c=%0d got %b want %b", c, running[0], (c < 12)); else pass_cnt++;
      total_cnt++; if (any_pulse !== (c == 13)) $display("FAIL single_any_pulse c=%0d got %b want %b", c, any_pulse, (c == 13)); else pass_cnt++;
      if (c == 1) start[0] = 1'b0;
    end
  endtask

  // ch0 L=2 with pause held through cycles 3..7: expiry slips from 8 to 13.
  task automatic test_pause();
    logic [7:0] exp_c;
    load_value[7:0] = 8'd2;
    start[0] = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      exp_c = (c <= 8) ? 8'd2 : (c <= 12) ? 8'd1 : 8'd0;
      total_cnt++; if (count[7:0] !== exp_c) $display("FAIL pause_count c=%0d got %0d want %0d", c, count[7:0], exp_c); else pass_cnt++;
      total_cnt++; if (done_pulse[0] !== (c == 13)) $display("FAIL pause_pulse c=%0d got %b want %b", c, done_pulse[0], (c == 13)); else pass_cnt++;
      total_cnt++; if (running[0] !== (c < 13)) $display("FAIL pause_running c=%0d got %b want %b", c, running[0], (c < 13)); else pass_cnt++;
      if (c == 1) start[0] = 1'b0;
      pause[0] = (c >= 3 && c <= 7);
    end
  endtask

  // ch1 L=2 periodic: pulses at 8, 16, 24, count reloads to 2, done stays low.
  task automatic test_reload();
    logic [7:0] exp_c;
    load_value[15:8] = 8'd2;
    reload_en[1] = 1'b1;
    start[1] = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      step();
      exp_c = ((c % 8) >= 4) ? 8'd1 : 8'd2;
      total_cnt++; if (count[15:8] !== exp_c) $display("FAIL reload_count c=%0d got %0d want %0d", c, count[15:8], exp_c); else pass_cnt++;
      total_cnt++; if (done_pulse[1] !== (c == 8 || c == 16 || c == 24)) $display("FAIL reload_pulse c=%0d got %b want %b", c, done_pulse[1], (c == 8 || c == 16 || c == 24)); else pass_cnt++;
      total_cnt++; if (done[1] !== 1'b0) $display("FAIL reload_done c=%0d got %b want 0", c, done[1]); else pass_cnt++;
      total_cnt++; if (done[0] !== 1'b1) $display("FAIL reload_ch0_idle c=%0d got %b want 1", c, done[0]); else pass_cnt++;
      if (c == 1) start[1] = 1'b0;
    end
    reload_en[1] = 1'b0;
    clear[1] = 1'b1;
    step();
    total_cnt++; if (count[15:8] !== 8'd0) $display("FAIL reload_clear_count got %0d want 0", count[15:8]); else pass_cnt++;
    total_cnt++; if (done[1] !== 1'b1) $display("FAIL reload_clear_done got %b want 1", done[1]); else pass_cnt++;
    clear[1] = 1'b0;
    step();
  endtask

  // ch0 L=5 cleared at cycle 6, restarted with L=1 at cycle 10, expiring at 14.
  task automatic test_clear();
    logic [7:0] exp_c;
    logic       exp_d;
    load_value[7:0] = 8'd5;
    start[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      exp_c = (c <= 3) ? 8'd5 : (c <= 6) ? 8'd4 : (c <= 10) ? 8'd0 : (c <= 13) ? 8'd1 : 8'd0;
      exp_d = (c >= 7 && c <= 10) || (c >= 14);
      total_cnt++; if (count[7:0] !== exp_c) $display("FAIL clear_count c=%0d got %0d want %0d", c, count[7:0], exp_c); else pass_cnt++;
      total_cnt++; if (done[0] !== exp_d) $display("FAIL clear_done c=%0d got %b want %b", c, done[0], exp_d); else pass_cnt++;
      total_cnt++; if (done_pulse[0] !== (c == 14)) $display("FAIL clear_pulse c=%0d got %b want %b", c, done_pulse[0], (c == 14)); else pass_cnt++;
      total_cnt++; if (running[0] !== !exp_d) $display("FAIL clear_running c=%0d got %b want %b", c, running[0], !exp_d); else pass_cnt++;
      if (c == 1) start[0] = 1'b0;
      clear[0] = (c == 6);
      if (c == 10) begin
        load_value[7:0] = 8'd1;
        start[0] = 1'b1;
      end
      if (c == 11) start[0] = 1'b0;
    end
  endtask

  // Start and clear edges together: clear wins. Then a start with L=0 expires at once.
  task automatic test_clear_vs_start();
    load_value[7:0] = 8'd4;
    start[0] = 1'b1;
    clear[0] = 1'b1;
    step();
    total_cnt++; if (count[7:0] !== 8'd0) $display("FAIL prio_count got %0d want 0", count[7:0]); else pass_cnt++;
    total_cnt++; if (done[0] !== 1'b1) $display("FAIL prio_done got %b want 1", done[0]); else pass_cnt++;
    total_cnt++; if (running[0] !== 1'b0) $display("FAIL prio_running got %b want 0", running[0]); else pass_cnt++;
    total_cnt++; if (done_pulse[0] !== 1'b0) $display("FAIL prio_pulse got %b want 0", done_pulse[0]); else pass_cnt++;
    start[0] = 1'b0;
    clear[0] = 1'b0;
    step();
    load_value[7:0] = 8'd0;
    start[0] = 1'b1;
    step();
    total_cnt++; if (done_pulse[0] !== 1'b1) $display("FAIL zero_pulse got %b want 1", done_pulse[0]); else pass_cnt++;
    total_cnt++; if (count[7:0] !== 8'd0) $display("FAIL zero_count got %0d want 0", count[7:0]); else pass_cnt++;
    total_cnt++; if (done[0] !== 1'b1) $display("FAIL zero_done got %b want 1", done[0]); else pass_cnt++;
    total_cnt++; if (running[0] !== 1'b0) $display("FAIL zero_running got %b want 0", running[0]); else pass_cnt++;
    start[0] = 1'b0;
    step();
    total_cnt++; if (done_pulse[0] !== 1'b0) $display("FAIL zero_pulse_width got %b want 0", done_pulse[0]); else pass_cnt++;
    total_cnt++; if (any_pulse !== 1'b1) $display("FAIL zero_any_pulse got %b want 1", any_pulse); else pass_cnt++;
    step();
  endtask

  // Both channels started together (L=1 / L=2), then a restart cut short by async reset at cycle 6.
  task automatic test_both_and_reset();
    logic [7:0] exp0, exp1;
    load_value = {8'd2, 8'd1};
    start = 2'b11;
    for (int c = 1; c <= 9; c++) begin
      step();
      exp0 = (c < 4) ? 8'd1 : 8'd0;
      exp1 = (c < 4) ? 8'd2 : (c < 8) ? 8'd1 : 8'd0;
      total_cnt++; if (count[7:0] !== exp0) $display("FAIL both_count0 c=%0d got %0d want %0d", c, count[7:0], exp0); else pass_cnt++;
      total_cnt++; if (count[15:8] !== exp1) $display("FAIL both_count1 c=%0d got %0d want %0d", c, count[15:8], exp1); else pass_cnt++;
      total_cnt++; if (done_pulse !== {(c == 8), (c == 4)}) $display("FAIL both_pulse c=%0d got %b want %b", c, done_pulse, {(c == 8), (c == 4)}); else pass_cnt++;
      total_cnt++; if (any_pulse !== (c == 5 || c == 9)) $display("FAIL both_any_pulse c=%0d got %b want %b", c, any_pulse, (c == 5 || c == 9)); else pass_cnt++;
      if (c == 1) start = 2'b00;
    end
    load_value = {8'd3, 8'd3};
    start = 2'b11;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) start = 2'b00;
    end
    total_cnt++; if (count !== {8'd2, 8'd2}) $display("FAIL prereset_count got %h want 0202", count); else pass_cnt++;
    rstn = 1'b0;
    #1;
    total_cnt++; if (count !== 16'h0000) $display("FAIL async_reset_count got %h want 0000", count); else pass_cnt++;
    total_cnt++; if (done !== 2'b11) $display("FAIL async_reset_done got %b want 11", done); else pass_cnt++;
    total_cnt++; if (running !== 2'b00) $display("FAIL async_reset_running got %b want 00", running); else pass_cnt++;
    total_cnt++; if (done_pulse !== 2'b00 || any_pulse !== 1'b0) $display("FAIL async_reset_pulses got %b/%b want 00/0", done_pulse, any_pulse); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    step();
    total_cnt++; if (done !== 2'b11) $display("FAIL post_reset_done got %b want 11", done); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_pause();
    test_reload();
    test_clear();
    test_clear_vs_start();
    test_both_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
